// File: rtl/wb_arb_pkg.sv
// Purpose: shared state and grant encodings for the two-master Wishbone arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Purpose: counts strobe-without-response cycles and pulses an error on a hung transfer.
// Latency: error pulses the cycle after TIMEOUT_CYCLES unanswered strobe cycles.
// Backpressure: none; the pulse forces the slave strobe low for that one cycle.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] grant_i,
  input  logic       stb_i,
  input  logic       ack_i,
  input  logic       err_i,
  output logic       wdog_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [1:0]    gprev_q;

  // Stall counter: a fresh grant counts its own first strobe cycle as 1, any response or idle strobe clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      gprev_q <= 2'b00;
    end else begin
      gprev_q <= grant_i;
      err_q   <= 1'b0;
      if (err_q || !stb_i || ack_i || err_i) begin
        cnt_q <= '0;
      end else if (grant_i != gprev_q) begin
        cnt_q <= CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign wdog_err_o = err_q;

endmodule

// File: rtl/wb_arbiter_2m.sv
// Purpose: round-robin two-master to one-slave Wishbone classic arbiter; optional watchdog under WB_ARB_TIMEOUT_EN.
// Latency: one cycle from cyc request (sampled in IDLE) to slave cyc/stb; responses are combinational.
// Backpressure: grant held for the whole cyc burst; the losing master simply waits with cyc high.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int          DW             = 32,
  parameter int          AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [DW-1:0]   m0_data_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_data_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [DW-1:0]   m1_data_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_data_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   s_data_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       last_m1_q;   // 1 when m1 held the most recent grant
  logic       gnt0, gnt1;
  logic       stb_raw;
  logic       wdog_err;
  logic       m0_live, m1_live;

  // Arbitration FSM: no preemption while the owner holds cyc, hand over directly on release, round-robin on ties
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      last_m1_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_m1_q)) begin
            state_q   <= ST_GNT0;
            grant_q   <= GNT_M0;
            last_m1_q <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q   <= ST_GNT1;
            grant_q   <= GNT_M1;
            last_m1_q <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_q   <= ST_GNT1;
              grant_q   <= GNT_M1;
              last_m1_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= GNT_NONE;
            end
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state_q   <= ST_GNT0;
              grant_q   <= GNT_M0;
              last_m1_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= GNT_NONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= GNT_NONE;
        end
      endcase
    end
  end

  assign gnt0    = (state_q == ST_GNT0);
  assign gnt1    = (state_q == ST_GNT1);
  assign m0_live = gnt0 & m0_cyc_i & m0_stb_i;
  assign m1_live = gnt1 & m1_cyc_i & m1_stb_i;
  assign stb_raw = m0_live | m1_live;

  // Slave-side mux driven from the registered owner; everything is zero while idle
  always_comb begin
    s_data_o = '0;
    s_addr_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    if (gnt0) begin
      s_data_o = m0_data_i;
      s_addr_o = m0_addr_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      s_cyc_o  = m0_cyc_i;
    end else if (gnt1) begin
      s_data_o = m1_data_i;
      s_addr_o = m1_addr_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_cyc_o  = m1_cyc_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .grant_i    (grant_q),
    .stb_i      (stb_raw),
    .ack_i      (s_ack_i),
    .err_i      (s_err_i),
    .wdog_err_o (wdog_err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
  assign wdog_err = 1'b0;
`endif

  // The strobe is withdrawn in the cycle the watchdog aborts the transfer
  assign s_stb_o = stb_raw & ~wdog_err;

  assign m0_ack_o  = s_ack_i & m0_live;
  assign m1_ack_o  = s_ack_i & m1_live;
  assign m0_err_o  = (s_err_i | wdog_err) & m0_live;
  assign m1_err_o  = (s_err_i | wdog_err) & m1_live;
  assign m0_data_o = gnt0 ? s_data_i : '0;
  assign m1_data_o = gnt1 ? s_data_i : '0;
  assign grant_o   = grant_q;

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone classic arbiter sharing a single slave channel, typically the DDR2 controller, between the OpenMIPS data port (m0) and instruction port (m1).
- Sits between the processor Wishbone ports and one wb_conmax master input, or directly in front of a slave.
- Round-robin grant is held for the whole cyc_i burst; slave ack/err are routed only to the granted master.
- An optional watchdog terminates hung transfers with an error.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- TIMEOUT_CYCLES, 1024, cycles of stb-without-ack before watchdog error (only with WB_ARB_TIMEOUT_EN); must be >= 2.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- m0_data_i  in  DW  master 0 write data
- m0_addr_i  in  AW  master 0 address
- m0_sel_i  in  DW/8  master 0 byte select
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle
- m0_stb_i  in  1  master 0 strobe
- m0_data_o  out  DW  read data to master 0
- m0_ack_o  out  1  ack to master 0
- m0_err_o  out  1  error to master 0
- m1_*  same set as m0_*, for master 1
- s_data_o  out  DW  write data to slave
- s_addr_o  out  AW  address to slave
- s_sel_o  out  DW/8  byte select to slave
- s_we_o  out  1  write enable to slave
- s_cyc_o  out  1  cycle to slave
- s_stb_o  out  1  strobe to slave
- s_data_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave error
- grant_o  out  2  one-hot registered grant {m1,m0}; 00 when idle

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset state: FSM in IDLE, grant_o=00, last_grant=m1 (so m0 wins the first tie), watchdog counter=0.
  - All s_* outputs are 0: s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_data_o.
  - All m*_ack_o and m*_err_o are 0.
  - m*_data_o is 0 while idle.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Only m0_cyc_i -> GNT0.
  - Only m1_cyc_i -> GNT1.
  - Both -> grant the master that is not last_grant.
  - Neither -> stay IDLE.
  - Grant latency is 1 cycle: the request is sampled in IDLE, and the slave sees cyc/stb the following cycle.
- GNTx:
  - While mx_cyc_i=1, stay in GNTx; no preemption.
  - When mx_cyc_i=0 and the other master's cyc_i=1 -> go directly to that master's GNT state (no idle bubble).
  - When mx_cyc_i=0 and the other master is not requesting -> IDLE.
  - last_grant is updated to x on entry to GNTx.
- Output muxing is combinational from the registered state.
  - In GNTx: s_{data,addr,sel,we}_o = mx_*; s_cyc_o = mx_cyc_i; s_stb_o = mx_cyc_i & mx_stb_i.
  - In IDLE: all s_* outputs are 0.
- Response routing:
  - mx_ack_o = s_ack_i & GNTx & mx_cyc_i & mx_stb_i.
  - mx_err_o = (s_err_i | wdog_err) under the same qualification.
  - The non-granted master always sees ack=0 and err=0.
  - m*_data_o = s_data_i, driven to the granted master only; the other master sees 0.
- A master dropping stb while keeping cyc high retains the grant (block/RMW transfers).
- A spurious s_ack_i while in IDLE is ignored.
- Reset mid-transfer: the next cycle is IDLE and all outputs are 0; the in-flight transfer is abandoned.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle with s_stb_o=1 & s_ack_i=0 & s_err_i=0.
  - Counter clears on ack, err, stb low, or grant change.
  - When the counter reaches TIMEOUT_CYCLES-1, wdog_err pulses for 1 cycle; the granted master sees err_o=1 and the counter clears.
  - s_stb_o is forced to 0 in that cycle.
- Undefined: no counter; err_o = qualified s_err_i only; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - grant encodings GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- One natural sub-module, wb_arb_watchdog: the counter and pulse logic, instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- After reset, m0 only: cyc/stb with addr=0x0000_0010, we=1, data=0xDEADBEEF, slave ack after 3 cycles.
  - Expect grant_o=01 one cycle after the request, s_addr_o=0x10, s_data_o=0xDEADBEEF.
  - Expect m0_ack_o for exactly 1 cycle; m1_ack_o stays 0.
- Simultaneous m0 and m1 request from IDLE after reset.
  - Expect m0 granted first.
  - m0 drops cyc -> grant_o=10 on the next cycle with no IDLE cycle; s_addr_o switches to m1_addr_i.
- Both masters request continuously for 4 single transfers each.
  - Expect strict alternation of grant_o: 01, 10, 01, 10 …
  - Neither master is starved.
- Burst hold: m1 holds cyc for 4 acked reads (s_data_i=0x1,0x2,0x3,0x4) while m0 requests.
  - Expect grant_o=10 throughout; m1_data_o returns 0x1..0x4 in order.
  - m0 is granted only after m1 drops cyc.
- Reset mid-transfer: assert wb_rst_i while in GNT0 with stb pending.
  - Next cycle: s_cyc_o=0, grant_o=00, all acks and errs 0.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: m0 strobes and the slave never acks.
  - Expect m0_err_o=1 exactly 8 cycles after s_stb_o first rises, with s_stb_o=0 in that cycle.
  - Counter restarts afterwards.
  - With the macro undefined: no err, and the transfer stays pending.
